// File: rtl/cnn_frame_sequencer.sv
// Frame sequencer for one MNIST inference: it flushes the CNN pipeline, streams the image
// pixels from memory into conv1, then waits for the comparator decision under a watchdog.
module cnn_frame_sequencer #(
    parameter int IMG_PIXELS   = 784,
    parameter int ADDR_BITS    = 16,
    parameter int PIX_BITS     = 8,
    parameter int FLUSH_CYCLES = 4,
    parameter int TIMEOUT      = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [ADDR_BITS-1:0] img_base,
    output logic                 mem_rd_en,
    output logic [ADDR_BITS-1:0] mem_addr,
    input  logic [PIX_BITS-1:0]  mem_rdata,
    output logic [PIX_BITS-1:0]  pix_data,
    output logic                 pix_valid,
    output logic                 pipe_rst_n,
    input  logic                 result_valid,
    input  logic [3:0]           result_decision,
    output logic                 busy,
    output logic                 done,
    output logic [3:0]           decision,
    output logic                 timeout
);

    localparam int CNT_MAX  = (TIMEOUT > IMG_PIXELS) ?
                              ((TIMEOUT > FLUSH_CYCLES) ? TIMEOUT : FLUSH_CYCLES) :
                              ((IMG_PIXELS > FLUSH_CYCLES) ? IMG_PIXELS : FLUSH_CYCLES);
    localparam int CNT_BITS = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [CNT_BITS-1:0] r_cnt;
    logic                r_rd_d1;   // read issued last cycle: mem_rdata is valid now
    logic                w_active;

    assign w_active = (r_state == S_FLUSH) || (r_state == S_STREAM) || (r_state == S_DRAIN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_rd_d1    <= 1'b0;
            mem_rd_en  <= 1'b0;
            mem_addr   <= '0;
            pix_data   <= '0;
            pix_valid  <= 1'b0;
            pipe_rst_n <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            decision   <= '0;
            timeout    <= 1'b0;
        end else begin
            // Two-stage pixel return path: memory latency, then the pix_data register.
            r_rd_d1   <= mem_rd_en;
            pix_valid <= r_rd_d1;
            pix_data  <= r_rd_d1 ? mem_rdata : '0;
            done      <= 1'b0;

            // NOTE: abort is decoded ahead of the per-state case so it overrides start,
            // result_valid and the pixel path in the same cycle.
            if (abort && w_active) begin
                r_state    <= S_IDLE;
                r_cnt      <= '0;
                r_rd_d1    <= 1'b0;
                mem_rd_en  <= 1'b0;
                pix_valid  <= 1'b0;
                pix_data   <= '0;
                pipe_rst_n <= 1'b0;
                busy       <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        pipe_rst_n <= 1'b1;
                        if (start && !abort) begin
                            r_state    <= S_FLUSH;
                            r_cnt      <= '0;
                            mem_addr   <= img_base;
                            timeout    <= 1'b0;
                            busy       <= 1'b1;
                            pipe_rst_n <= 1'b0;
                        end
                    end
                    S_FLUSH: begin
                        if (r_cnt == CNT_BITS'(FLUSH_CYCLES - 1)) begin
                            r_state    <= S_STREAM;
                            r_cnt      <= '0;
                            pipe_rst_n <= 1'b1;
                            mem_rd_en  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_BITS'(1);
                        end
                    end
                    S_STREAM: begin
                        if (r_cnt == CNT_BITS'(IMG_PIXELS - 1)) begin
                            r_state   <= S_DRAIN;
                            r_cnt     <= '0;
                            mem_rd_en <= 1'b0;
                        end else begin
                            r_cnt    <= r_cnt + CNT_BITS'(1);
                            mem_addr <= mem_addr + ADDR_BITS'(1);
                        end
                    end
                    S_DRAIN: begin
                        if (result_valid) begin
                            r_state  <= S_DONE;
                            decision <= result_decision;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                        end else if (r_cnt == CNT_BITS'(TIMEOUT - 1)) begin
                            r_state <= S_DONE;
                            timeout <= 1'b1;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + CNT_BITS'(1);
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// Scoreboard bench for cnn_frame_sequencer: stimulus queues expected addresses, pixels and
// done results; a negedge monitor pops and compares whenever the DUT presents them.
module tb_cnn_frame_sequencer;

    localparam int IMG_PIXELS   = 784;
    localparam int ADDR_BITS    = 16;
    localparam int PIX_BITS     = 8;
    localparam int FLUSH_CYCLES = 4;
    localparam int TIMEOUT      = 4096;

    typedef struct packed {
        logic [3:0] dec;
        logic       to;
    } done_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic                 abort = 1'b0;
    logic [ADDR_BITS-1:0] img_base = '0;
    logic                 mem_rd_en;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [PIX_BITS-1:0]  mem_rdata = '0;
    logic [PIX_BITS-1:0]  pix_data;
    logic                 pix_valid;
    logic                 pipe_rst_n;
    logic                 result_valid = 1'b0;
    logic [3:0]           result_decision = '0;
    logic                 busy;
    logic                 done;
    logic [3:0]           decision;
    logic                 timeout;

    int checks = 0;
    int failures = 0;

    logic [ADDR_BITS-1:0] exp_addr[$];
    logic [PIX_BITS-1:0]  exp_pix[$];
    done_t                exp_done[$];

    cnn_frame_sequencer #(
        .IMG_PIXELS  (IMG_PIXELS),
        .ADDR_BITS   (ADDR_BITS),
        .PIX_BITS    (PIX_BITS),
        .FLUSH_CYCLES(FLUSH_CYCLES),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .abort          (abort),
        .img_base       (img_base),
        .mem_rd_en      (mem_rd_en),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .pix_data       (pix_data),
        .pix_valid      (pix_valid),
        .pipe_rst_n     (pipe_rst_n),
        .result_valid   (result_valid),
        .result_decision(result_decision),
        .busy           (busy),
        .done           (done),
        .decision       (decision),
        .timeout        (timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [PIX_BITS-1:0] pix_of(input logic [ADDR_BITS-1:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hA5;
    endfunction

    // Pixel memory with one cycle of read latency.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= pix_of(mem_addr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: event seen, none expected", name);
    endtask

    task automatic expect_frame(input logic [ADDR_BITS-1:0] base, input int n_addr, input int n_pix);
        for (int k = 0; k < n_addr; k++) exp_addr.push_back(base + ADDR_BITS'(k));
        for (int k = 0; k < n_pix; k++) exp_pix.push_back(pix_of(base + ADDR_BITS'(k)));
    endtask

    task automatic start_image(input logic [ADDR_BITS-1:0] base);
        @(negedge clk);
        img_base = base;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_rd_fall();
        bit prev = 1'b0;
        bit found = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (prev && !mem_rd_en) begin
                found = 1'b1;
                break;
            end
            prev = mem_rd_en;
        end
        if (!found) begin
            checks++;
            failures++;
            $display("FAIL drain_entry: stream end not seen within 4000 cycles");
        end
    endtask

    task automatic respond(input logic [3:0] dec, input int delay);
        wait_rd_fall();
        repeat (delay) @(negedge clk);
        result_decision = dec;
        result_valid    = 1'b1;
        @(posedge clk);
        #1 result_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit found = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (done) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            checks++;
            failures++;
            $display("FAIL done_wait: done not seen within 6000 cycles");
        end
    endtask

    // Monitor: compares every address, pixel and done against the scoreboard queues.
    always @(negedge clk) begin : monitor
        logic [ADDR_BITS-1:0] ea;
        logic [PIX_BITS-1:0]  ep;
        done_t                ed;
        if (!rst) begin
            if (mem_rd_en) begin
                if (exp_addr.size() == 0) note_fail("addr_unexpected");
                else begin
                    ea = exp_addr.pop_front();
                    check("mem_addr", 32'(mem_addr), 32'(ea));
                end
            end
            if (pix_valid) begin
                if (exp_pix.size() == 0) note_fail("pix_unexpected");
                else begin
                    ep = exp_pix.pop_front();
                    check("pix_data", 32'(pix_data), 32'(ep));
                end
            end else begin
                check("pix_data_idle_zero", 32'(pix_data), 32'd0);
            end
            if (done) begin
                if (exp_done.size() == 0) note_fail("done_unexpected");
                else begin
                    ed = exp_done.pop_front();
                    check("done_decision", 32'(decision), 32'(ed.dec));
                    check("done_timeout", 32'(timeout), 32'(ed.to));
                    check("busy_at_done", 32'(busy), 32'd0);
                end
            end
        end
    end

    initial begin : watchdog
        #5ms;
        $display("FAIL global_watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int n;
        int cnt;

        // Reset values
        @(negedge clk);
        check("rst_pipe_rst_n", 32'(pipe_rst_n), 32'd0);
        check("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_decision", 32'(decision), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_pix_valid", 32'(pix_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_pipe_rst_n", 32'(pipe_rst_n), 32'd1);

        // Image at base 0: flush length, full stream, decision 3
        expect_frame(16'h0000, IMG_PIXELS, IMG_PIXELS);
        exp_done.push_back('{dec: 4'd3, to: 1'b0});
        start_image(16'h0000);
        n = 0;
        while (!pipe_rst_n && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("flush_cycles", 32'(n), 32'(FLUSH_CYCLES));
        check("stream_starts_after_flush", 32'(mem_rd_en), 32'd1);
        check("busy_in_stream", 32'(busy), 32'd1);
        respond(4'd3, 10);
        wait_done();
        check("img1_reads_consumed", 32'(exp_addr.size()), 32'd0);

        // Address wrap from FF00
        expect_frame(16'hFF00, IMG_PIXELS, IMG_PIXELS);
        exp_done.push_back('{dec: 4'd7, to: 1'b0});
        start_image(16'hFF00);
        respond(4'd7, 20);
        wait_done();

        // No result: watchdog timeout, decision keeps 7
        expect_frame(16'h1234, IMG_PIXELS, IMG_PIXELS);
        exp_done.push_back('{dec: 4'd7, to: 1'b1});
        start_image(16'h1234);
        wait_rd_fall();
        n = 0;
        while (!done && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("timeout_latency", 32'(n), 32'(TIMEOUT));
        @(negedge clk);
        check("timeout_sticky", 32'(timeout), 32'd1);

        // Abort at stream pixel 100: 101 reads seen, 99 pixels delivered, no done
        expect_frame(16'h0100, 101, 99);
        start_image(16'h0100);
        check("timeout_cleared_on_start", 32'(timeout), 32'd0);
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (mem_rd_en) cnt++;
            if (cnt == 101) break;
        end
        check("abort_reached_pixel100", 32'(cnt), 32'd101);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_mem_rd_en", 32'(mem_rd_en), 32'd0);
        check("abort_pipe_rst_n", 32'(pipe_rst_n), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_pix_valid", 32'(pix_valid), 32'd0);
        check("abort_decision_kept", 32'(decision), 32'd7);
        @(negedge clk);
        check("abort_pipe_rst_release", 32'(pipe_rst_n), 32'd1);
        repeat (20) @(negedge clk);

        // abort in IDLE has no effect and beats a coincident start
        img_base = 16'h0500;
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("abort_beats_start_busy", 32'(busy), 32'd0);
        check("abort_idle_pipe_rst_n", 32'(pipe_rst_n), 32'd1);

        // Normal image after abort, result on the first DRAIN cycle
        expect_frame(16'h0200, IMG_PIXELS, IMG_PIXELS);
        exp_done.push_back('{dec: 4'd5, to: 1'b0});
        start_image(16'h0200);
        respond(4'd5, 0);
        wait_done();

        // start held high: back-to-back images, spurious result in STREAM ignored
        expect_frame(16'h0300, IMG_PIXELS, IMG_PIXELS);
        expect_frame(16'h0300, IMG_PIXELS, IMG_PIXELS);
        exp_done.push_back('{dec: 4'd9, to: 1'b0});
        exp_done.push_back('{dec: 4'd2, to: 1'b0});
        @(negedge clk);
        img_base = 16'h0300;
        start    = 1'b1;
        repeat (60) @(negedge clk);
        check("spurious_in_stream", 32'(mem_rd_en), 32'd1);
        result_decision = 4'hF;
        result_valid    = 1'b1;
        @(posedge clk);
        #1 result_valid = 1'b0;
        respond(4'd9, 5);
        wait_done();
        @(negedge clk);
        check("b2b_idle_busy", 32'(busy), 32'd0);
        check("b2b_idle_pipe_rst_n", 32'(pipe_rst_n), 32'd1);
        @(negedge clk);
        check("b2b_flush_busy", 32'(busy), 32'd1);
        check("b2b_flush_pipe_rst_n", 32'(pipe_rst_n), 32'd0);
        start = 1'b0;
        respond(4'd2, 3);
        wait_done();

        // Asynchronous reset in DRAIN
        expect_frame(16'h0400, IMG_PIXELS, IMG_PIXELS);
        start_image(16'h0400);
        wait_rd_fall();
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_pipe_rst_n", 32'(pipe_rst_n), 32'd0);
        check("arst_decision", 32'(decision), 32'd0);
        check("arst_timeout", 32'(timeout), 32'd0);
        check("arst_mem_addr", 32'(mem_addr), 32'd0);
        check("arst_mem_rd_en", 32'(mem_rd_en), 32'd0);
        check("arst_pix_valid", 32'(pix_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("arst_hold_pipe_rst_n", 32'(pipe_rst_n), 32'd0);
        @(negedge clk);
        check("arst_release_pipe_rst_n", 32'(pipe_rst_n), 32'd1);
        check("arst_release_busy", 32'(busy), 32'd0);
        repeat (10) @(negedge clk);

        check("addr_queue_empty", 32'(exp_addr.size()), 32'd0);
        check("pix_queue_empty", 32'(exp_pix.size()), 32'd0);
        check("done_queue_empty", 32'(exp_done.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
